rx_token_decoder: RTL and testbench



---
 rtl/rx_token_decoder.sv | 146 ++++++++++++++
 tb/tb_rx_token_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_token_decoder.sv
// rx_token_decoder: decodes received link characters into NULL/FCT/N-Char/time-code
// events, tracks receive credit and latches sticky parity, escape and credit errors.
module rx_token_decoder (
    input  logic       posedge_clk,
    input  logic       rx_reset,
    input  logic       char_valid,
    input  logic       is_control,
    input  logic [2:0] control_p_r,
    input  logic [8:0] dta_timec_p,
    input  logic       parity_rec_c,
    input  logic       parity_rec_c_gen,
    input  logic       parity_rec_d,
    input  logic       parity_rec_d_gen,
    input  logic       fct_sent,
    output logic       rx_got_null,
    output logic       rx_got_fct,
    output logic       rx_got_nchar,
    output logic       rx_got_time_code,
    output logic [8:0] rx_data_out,
    output logic       rx_data_valid,
    output logic [7:0] rx_time_out,
    output logic       rx_tick_out,
    output logic [5:0] rx_credit,
    output logic       rx_error_parity,
    output logic       rx_error_esc,
    output logic       rx_error_credit
);
    typedef enum logic [1:0] {WAIT_NULL, RUN, ESC_PEND, ERROR} state_t;
    state_t     state_q, state_d;
    logic       null_seen_q, null_seen_d, first_q, first_d;
    logic       got_null_q, got_null_d, got_fct_q, got_fct_d, got_nchar_q, got_nchar_d;
    logic       got_tc_q, got_tc_d, valid_q, valid_d;
    logic [8:0] data_q, data_d;
    logic [7:0] time_q, time_d;
    logic [5:0] credit_q, credit_d;
    logic       err_par_q, err_par_d, err_esc_q, err_esc_d, err_cred_q, err_cred_d;
    logic [1:0] code;
    logic       par_err, is_esc, is_fct, fct_ok;
    always_comb begin
        code        = control_p_r[1:0];
        par_err     = is_control ? (parity_rec_c != parity_rec_c_gen) : (parity_rec_d != parity_rec_d_gen);
        is_esc      = is_control && code == 2'b11;
        is_fct      = is_control && code == 2'b00;
        fct_ok      = fct_sent && credit_q <= 6'd48 && state_q != ERROR;
        state_d     = state_q;
        null_seen_d = null_seen_q;
        first_d     = first_q;
        got_null_d  = 1'b0;
        got_fct_d   = 1'b0;
        got_nchar_d = 1'b0;
        got_tc_d    = 1'b0;
        valid_d     = 1'b0;
        data_d      = data_q;
        time_d      = time_q;
        err_par_d   = err_par_q;
        err_esc_d   = err_esc_q;
        err_cred_d  = err_cred_q;
        if (char_valid && state_q != ERROR) begin
            first_d = 1'b0;
            if (par_err && !first_q) begin
                err_par_d = 1'b1;
                state_d   = ERROR;
            end else begin
                case (state_q)
                    WAIT_NULL: state_d = is_esc ? ESC_PEND : WAIT_NULL;
                    RUN: begin
                        if (is_esc)
                            state_d = ESC_PEND;
                        else if (is_fct)
                            got_fct_d = 1'b1;
                        else if (credit_q == 6'd0 && !fct_ok) begin
                            err_cred_d = 1'b1;
                            state_d    = ERROR;
                        end else begin
                            valid_d     = 1'b1;
                            got_nchar_d = 1'b1;
                            data_d      = is_control ? {1'b1, 7'd0, code[1]} : {1'b0, dta_timec_p[7:0]};
                        end
                    end
                    ESC_PEND: begin
                        if (is_fct) begin
                            got_null_d  = 1'b1;
                            null_seen_d = 1'b1;
                            state_d     = RUN;
                        end else if (!is_control) begin
                            // a time-code is only meaningful once the link has seen a NULL
                            time_d   = null_seen_q ? dta_timec_p[7:0] : time_q;
                            got_tc_d = null_seen_q;
                            state_d  = null_seen_q ? RUN : WAIT_NULL;
                        end else begin
                            err_esc_d = 1'b1;
                            state_d   = ERROR;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
        credit_d = credit_q + (fct_ok ? 6'd8 : 6'd0) - (valid_d ? 6'd1 : 6'd0);
    end
    always_ff @(posedge posedge_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state_q     <= WAIT_NULL;
            null_seen_q <= 1'b0;
            first_q     <= 1'b1;
            got_null_q  <= 1'b0;
            got_fct_q   <= 1'b0;
            got_nchar_q <= 1'b0;
            got_tc_q    <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 9'd0;
            time_q      <= 8'd0;
            credit_q    <= 6'd0;
            err_par_q   <= 1'b0;
            err_esc_q   <= 1'b0;
            err_cred_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            null_seen_q <= null_seen_d;
            first_q     <= first_d;
            got_null_q  <= got_null_d;
            got_fct_q   <= got_fct_d;
            got_nchar_q <= got_nchar_d;
            got_tc_q    <= got_tc_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            time_q      <= time_d;
            credit_q    <= credit_d;
            err_par_q   <= err_par_d;
            err_esc_q   <= err_esc_d;
            err_cred_q  <= err_cred_d;
        end
    end
    assign rx_got_null      = got_null_q;
    assign rx_got_fct       = got_fct_q;
    assign rx_got_nchar     = got_nchar_q;
    assign rx_got_time_code = got_tc_q;
    assign rx_tick_out      = got_tc_q;
    assign rx_data_valid    = valid_q;
    assign rx_data_out      = data_q;
    assign rx_time_out      = time_q;
    assign rx_credit        = credit_q;
    assign rx_error_parity  = err_par_q;
    assign rx_error_esc     = err_esc_q;
    assign rx_error_credit  = err_cred_q;
endmodule

// File: tb/tb_rx_token_decoder.sv
// tb_rx_token_decoder: directed and random character streams scored against a
// flag-based behavioural model through an expected-response queue.
module tb_rx_token_decoder;
    logic       clk = 1'b0;
    logic       rx_reset, char_valid, is_control, fct_sent;
    logic [2:0] control_p_r;
    logic [8:0] dta_timec_p;
    logic       parity_rec_c, parity_rec_c_gen, parity_rec_d, parity_rec_d_gen;
    logic       rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code;
    logic [8:0] rx_data_out;
    logic       rx_data_valid, rx_tick_out;
    logic [7:0] rx_time_out;
    logic [5:0] rx_credit;
    logic       rx_error_parity, rx_error_esc, rx_error_credit;

    rx_token_decoder dut (
        .posedge_clk(clk), .rx_reset(rx_reset), .char_valid(char_valid), .is_control(is_control),
        .control_p_r(control_p_r), .dta_timec_p(dta_timec_p),
        .parity_rec_c(parity_rec_c), .parity_rec_c_gen(parity_rec_c_gen),
        .parity_rec_d(parity_rec_d), .parity_rec_d_gen(parity_rec_d_gen), .fct_sent(fct_sent),
        .rx_got_null(rx_got_null), .rx_got_fct(rx_got_fct), .rx_got_nchar(rx_got_nchar),
        .rx_got_time_code(rx_got_time_code), .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
        .rx_time_out(rx_time_out), .rx_tick_out(rx_tick_out), .rx_credit(rx_credit),
        .rx_error_parity(rx_error_parity), .rx_error_esc(rx_error_esc), .rx_error_credit(rx_error_credit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] ev;
        logic [8:0] data;
        logic [7:0] tm;
        logic [5:0] cr;
        logic [2:0] er;
    } snap_t;

    snap_t q[$];
    int compared = 0, mismatched = 0;

    bit   m_dead, m_escp, m_run, m_link, m_ep, m_ee, m_ec;
    int   m_chars, m_credit;
    logic [7:0] m_time;

    function automatic void chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_dead = 0; m_escp = 0; m_run = 0; m_link = 0;
        m_ep = 0; m_ee = 0; m_ec = 0;
        m_chars = 0; m_credit = 0; m_time = 8'd0;
    endfunction

    // ev = {null, fct, nchar, time_code, tick, valid, unused}
    function automatic snap_t model_step(bit cv, bit ctl, bit [1:0] code, bit [7:0] b, bit perr, bit fct);
        snap_t s;
        bit grant, took;
        s = '0;
        grant = fct && !m_dead && m_credit <= 48;
        took = 0;
        if (cv && !m_dead) begin
            m_chars++;
            if (perr && m_chars > 1) begin
                m_ep = 1; m_dead = 1;
            end else if (m_escp) begin
                m_escp = 0;
                if (ctl && code == 0) begin
                    s.ev[6] = 1; m_link = 1; m_run = 1;
                end else if (!ctl) begin
                    if (m_link) begin
                        m_time = b; s.ev[3] = 1; s.ev[2] = 1; m_run = 1;
                    end else m_run = 0;
                end else begin
                    m_ee = 1; m_dead = 1;
                end
            end else if (ctl && code == 3) m_escp = 1;
            else if (m_run) begin
                if (ctl && code == 0) s.ev[5] = 1;
                else if (m_credit == 0 && !grant) begin
                    m_ec = 1; m_dead = 1;
                end else begin
                    took = 1; s.ev[4] = 1; s.ev[1] = 1;
                    s.data = !ctl ? {1'b0, b} : (code == 1 ? 9'h100 : 9'h101);
                end
            end
        end
        m_credit = m_credit + (grant ? 8 : 0) - (took ? 1 : 0);
        s.tm = m_time;
        s.cr = 6'(m_credit);
        s.er = {m_ep, m_ee, m_ec};
        return s;
    endfunction

    task automatic send(bit cv, bit ctl, bit [1:0] code, bit [7:0] b, bit perr, bit fct);
        bit pc, pd;
        @(negedge clk);
        pc = 1'($urandom);
        pd = 1'($urandom);
        rx_reset = 1'b0;
        char_valid = cv;
        is_control = ctl;
        control_p_r = {1'($urandom), code};
        dta_timec_p = {1'($urandom), b};
        fct_sent = fct;
        parity_rec_c = pc;
        parity_rec_d = pd;
        parity_rec_c_gen = ctl ? pc ^ perr : 1'($urandom);
        parity_rec_d_gen = !ctl ? pd ^ perr : 1'($urandom);
        q.push_back(model_step(cv, ctl, code, b, perr, fct));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_reset = 1'b1;
        char_valid = 1'b0;
        fct_sent = 1'b0;
        model_reset();
        q.push_back('0);
        #1;
        chk("async_reset_credit", int'(rx_credit), 0);
        chk("async_reset_errors", int'({rx_error_parity, rx_error_esc, rx_error_credit}), 0);
    endtask

    task automatic ch(bit [1:0] code, bit fct = 0);
        send(1, 1, code, 8'h00, 0, fct);
    endtask

    task automatic dt(bit [7:0] b, bit perr = 0);
        send(1, 0, 2'b00, b, perr, 0);
    endtask

    task automatic idle(bit fct = 0);
        send(0, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), fct);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("got_null", int'(rx_got_null), int'(e.ev[6]));
                chk("got_fct", int'(rx_got_fct), int'(e.ev[5]));
                chk("got_nchar", int'(rx_got_nchar), int'(e.ev[4]));
                chk("got_time_code", int'(rx_got_time_code), int'(e.ev[3]));
                chk("tick_out", int'(rx_tick_out), int'(e.ev[2]));
                chk("data_valid", int'(rx_data_valid), int'(e.ev[1]));
                if (e.ev[1]) chk("data_out", int'(rx_data_out), int'(e.data));
                chk("time_out", int'(rx_time_out), int'(e.tm));
                chk("credit", int'(rx_credit), int'(e.cr));
                chk("err_flags", int'({rx_error_parity, rx_error_esc, rx_error_credit}), int'(e.er));
            end
        end
    end

    initial begin : driver
        int r, wait_cycles;
        rx_reset = 1'b1; char_valid = 1'b0; is_control = 1'b0; fct_sent = 1'b0;
        control_p_r = '0; dta_timec_p = '0;
        parity_rec_c = 0; parity_rec_c_gen = 0; parity_rec_d = 0; parity_rec_d_gen = 0;
        model_reset();
        do_reset();
        ch(3); ch(0); idle();
        do_reset();
        ch(3); ch(0); idle(1); dt(8'h5A); ch(1); idle();
        do_reset();
        ch(3); ch(0); ch(3); dt(8'h3F); idle();
        do_reset();
        ch(3); ch(0); ch(3); ch(1); ch(0); dt(8'h22); idle(1);
        do_reset();
        ch(3); ch(0); dt(8'h11); dt(8'h12); idle();
        do_reset();
        ch(3); dt(8'h44, 1); ch(0); dt(8'h55); do_reset(); idle();
        do_reset();
        dt(8'h01, 1); ch(3); dt(8'h77); ch(3); ch(0); dt(8'h66); idle();
        do_reset();
        ch(3); ch(0, 1); ch(2); ch(3); do_reset(); dt(8'h09);
        for (int i = 0; i < 8; i++) idle(1);
        ch(3); ch(0); ch(1); ch(2); idle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0 || (m_dead && $urandom_range(0, 4) == 0)) do_reset();
            else if ($urandom_range(0, 9) < 4) idle($urandom_range(0, 5) == 0);
            else begin
                r = $urandom_range(0, 99);
                send(1, r < 65, r < 30 ? 2'd3 : r < 50 ? 2'd0 : 2'($urandom_range(1, 2)),
                     8'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
            end
        end
        @(negedge clk);
        char_valid = 1'b0;
        fct_sent = 1'b0;
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
